multi_phase_baud_generator: RTL and testbench

// - NCO-style tick/clock generator built on an ACC_WIDTH phase accumulator; successor to the single-offset baud generator.
// - Emits NUM_PHASES phase-shifted tick strobes and square clocks from one shared accumulator.
// - Supports a runtime tuning word (glitch-free, applied at wrap), programmable per-channel offsets and a phase resync.
// - Sits between the system clock and the UART/serial samplers that need oversampling or multiphase strobes.

---
 rtl/phase_acc_pkg.sv | 37 +++
 rtl/phase_tap.sv | 57 +++++
 rtl/multi_phase_baud_generator.sv | 104 ++++++++++
 tb/tb_multi_phase_baud_generator.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/phase_acc_pkg.sv
// Shared constants and helpers for the phase-accumulator baud generator.
// Combinational only: constant functions evaluated at elaboration.
// No flow control here.
package phase_acc_pkg;

    localparam int unsigned SYS_CLK_FREQ_DEF = 125000000;
    localparam int unsigned BAUD_RATE_DEF    = 115200;
    localparam int unsigned ACC_WIDTH_DEF    = 32;

    typedef logic [ACC_WIDTH_DEF-1:0] acc_t;

    // Increment per clock that yields 'baud' wraps per second: round(baud*2^w/sys).
    function automatic logic [63:0] calc_tune(input longint unsigned sys,
                                              input longint unsigned baud,
                                              input int unsigned     w);
        logic [127:0] num;
        num = (128'(baud) << w) + 128'(sys >> 1);
        return 64'(num / 128'(sys));
    endfunction

    localparam logic [63:0] DEFAULT_TUNE = calc_tune(SYS_CLK_FREQ_DEF, BAUD_RATE_DEF, ACC_WIDTH_DEF);

    // Convert a phase in degrees into accumulator units (2^-w turn).
    function automatic logic [63:0] deg_to_offset(input int unsigned deg, input int unsigned w);
        logic [127:0] num;
        num = 128'(deg) << w;
        return 64'(num / 128'd360);
    endfunction

    // Equally spaced reset offset of channel k out of n: k*2^w/n, truncated.
    function automatic logic [63:0] equal_offset(input int unsigned k,
                                                 input int unsigned n,
                                                 input int unsigned w);
        return (64'(k) << w) / 64'(n);
    endfunction

endpackage

// File: rtl/phase_tap.sv
// One output channel: offset register plus carry detect on the offset phase.
// Latency: tick/gen_clock registered, 1 clk after the accumulator step.
// No backpressure; offset reloads only on sync.
module phase_tap #(
    parameter int                   ACC_WIDTH  = 32,
    parameter logic [ACC_WIDTH-1:0] RST_OFFSET = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 step_i,
    input  logic                 sync_i,
    input  logic [ACC_WIDTH-1:0] acc_i,
    input  logic [ACC_WIDTH-1:0] acc_nxt_i,
    input  logic [ACC_WIDTH-1:0] offset_i,
    output logic                 tick_o,
    output logic                 gen_clock_o
);

    logic [ACC_WIDTH-1:0] off_q, off_d;
    logic [ACC_WIDTH-1:0] ph, ph_nxt;
    logic                 tick_q, tick_d;
    logic                 gclk_q, gclk_d;

    assign ph     = acc_i + off_q;
    assign ph_nxt = acc_nxt_i + off_q;

    // A phase that gets smaller in one step has carried out: that is the tick.
    always_comb begin
        off_d  = off_q;
        tick_d = 1'b0;
        gclk_d = gclk_q;
        if (sync_i) begin
            off_d  = offset_i;
            gclk_d = offset_i[ACC_WIDTH-1];
        end else if (step_i) begin
            tick_d = (ph_nxt < ph);
            gclk_d = ph_nxt[ACC_WIDTH-1];
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            off_q  <= RST_OFFSET;
            tick_q <= 1'b0;
            gclk_q <= 1'b0;
        end else begin
            off_q  <= off_d;
            tick_q <= tick_d;
            gclk_q <= gclk_d;
        end
    end

    assign tick_o      = tick_q;
    assign gen_clock_o = gclk_q;

endmodule

// File: rtl/multi_phase_baud_generator.sv
// NCO baud/tick generator: one shared accumulator feeding NUM_PHASES offset taps.
// Latency: tick/gen_clock 1 clk after each accumulator step; tuning applied at acc wrap.
// Backpressure: tune_ready low while a tuning word waits for the wrap (or sync).
module multi_phase_baud_generator
    import phase_acc_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 125000000,
    parameter int BAUD_RATE    = 115200,
    parameter int ACC_WIDTH    = 32,
    parameter int NUM_PHASES   = 4
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            enable,
    input  logic [ACC_WIDTH-1:0]            tune_word,
    input  logic                            tune_valid,
    output logic                            tune_ready,
    input  logic [NUM_PHASES*ACC_WIDTH-1:0] phase_offset,
    input  logic                            sync,
    output logic [NUM_PHASES-1:0]           tick,
    output logic [NUM_PHASES-1:0]           gen_clock
);

    localparam logic [ACC_WIDTH-1:0] TUNE_RST =
        ACC_WIDTH'(calc_tune(SYS_CLK_FREQ, BAUD_RATE, ACC_WIDTH));

    logic [ACC_WIDTH-1:0] acc_q, acc_d, acc_nxt;
    logic [ACC_WIDTH-1:0] tune_act_q, tune_act_d;
    logic [ACC_WIDTH-1:0] tune_pend_q, tune_pend_d;
    logic                 pend_q, pend_d;
    logic                 step, acc_wrap, accept;

    assign acc_nxt    = acc_q + tune_act_q;
    assign step       = enable & ~sync;
    assign acc_wrap   = step & (acc_nxt < acc_q);
    assign accept     = tune_valid & ~pend_q;
    assign tune_ready = ~pend_q;

    // Accumulator advance and tuning handover; sync restarts phase and flushes any pending word.
    always_comb begin
        acc_d       = acc_q;
        tune_act_d  = tune_act_q;
        tune_pend_d = tune_pend_q;
        pend_d      = pend_q;
        if (sync) begin
            acc_d  = '0;
            pend_d = 1'b0;
            if (accept) begin
                tune_act_d = tune_word;
            end else if (pend_q) begin
                tune_act_d = tune_pend_q;
            end
        end else begin
            if (step) begin
                acc_d = acc_nxt;
            end
            // A zero increment never wraps, so a frozen accumulator takes the word at once.
            if (pend_q && (acc_wrap || (tune_act_q == '0))) begin
                tune_act_d = tune_pend_q;
                pend_d     = 1'b0;
            end
            if (accept) begin
                tune_pend_d = tune_word;
                pend_d      = 1'b1;
            end
        end
    end

    // Shared accumulator and tuning registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            tune_act_q  <= TUNE_RST;
            tune_pend_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            tune_act_q  <= tune_act_d;
            tune_pend_q <= tune_pend_d;
            pend_q      <= pend_d;
        end
    end

    for (genvar k = 0; k < NUM_PHASES; k++) begin : g_tap
        localparam logic [ACC_WIDTH-1:0] OFF_RST =
            ACC_WIDTH'(equal_offset(k, NUM_PHASES, ACC_WIDTH));

        phase_tap #(
            .ACC_WIDTH  (ACC_WIDTH),
            .RST_OFFSET (OFF_RST)
        ) u_tap (
            .clk         (clk),
            .rst_n       (reset_n),
            .step_i      (step),
            .sync_i      (sync),
            .acc_i       (acc_q),
            .acc_nxt_i   (acc_nxt),
            .offset_i    (phase_offset[k*ACC_WIDTH +: ACC_WIDTH]),
            .tick_o      (tick[k]),
            .gen_clock_o (gen_clock[k])
        );
    end

endmodule

// File: tb/tb_multi_phase_baud_generator.sv
// Directed bench: a default-parameter instance for rate/reset timing and an
// 8-bit instance for exact per-cycle tick/gen_clock patterns.
module tb_multi_phase_baud_generator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default-parameter instance
    logic         rst_b_n, en_b, tv_b, tr_b, sync_b;
    logic [31:0]  tw_b;
    logic [127:0] po_b;
    logic [3:0]   tick_b, gc_b;

    // 8-bit accumulator instance
    logic         rst_s_n, en_s, tv_s, tr_s, sync_s;
    logic [7:0]   tw_s;
    logic [31:0]  po_s;
    logic [3:0]   tick_s, gc_s;

    multi_phase_baud_generator u_big (
        .clk(clk), .reset_n(rst_b_n), .enable(en_b), .tune_word(tw_b),
        .tune_valid(tv_b), .tune_ready(tr_b), .phase_offset(po_b),
        .sync(sync_b), .tick(tick_b), .gen_clock(gc_b)
    );

    multi_phase_baud_generator #(.ACC_WIDTH(8), .NUM_PHASES(4)) u_small (
        .clk(clk), .reset_n(rst_s_n), .enable(en_s), .tune_word(tw_s),
        .tune_valid(tv_s), .tune_ready(tr_s), .phase_offset(po_s),
        .sync(sync_s), .tick(tick_s), .gen_clock(gc_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sync the small instance to offsets 0/64/128/192 and load 'tune' in the same cycle.
    task automatic sync_s_start(input logic [7:0] tune);
        sync_s = 1'b1;
        tv_s   = 1'b1;
        tw_s   = tune;
        po_s   = {8'd192, 8'd128, 8'd64, 8'd0};
        step();
        sync_s = 1'b0;
        tv_s   = 1'b0;
    endtask

    task automatic test_reset();
        step();
        step();
        checks++; if (tick_b !== 4'b0000) begin errors++; $display("FAIL reset_tick_big: got %b want 0000", tick_b); end
        checks++; if (gc_b !== 4'b0000)   begin errors++; $display("FAIL reset_gclk_big: got %b want 0000", gc_b); end
        checks++; if (tr_b !== 1'b1)      begin errors++; $display("FAIL reset_ready_big: got %b want 1", tr_b); end
        checks++; if (tick_s !== 4'b0000) begin errors++; $display("FAIL reset_tick_small: got %b want 0000", tick_s); end
        checks++; if (gc_s !== 4'b0000)   begin errors++; $display("FAIL reset_gclk_small: got %b want 0000", gc_s); end
        checks++; if (tr_s !== 1'b1)      begin errors++; $display("FAIL reset_ready_small: got %b want 1", tr_s); end
        rst_b_n = 1'b1;
        rst_s_n = 1'b1;
    endtask

    // 8-bit default tune rounds to 0: accumulator frozen, so a new word applies right after acceptance.
    task automatic test_frozen_apply();
        step();
        checks++; if (tick_s !== 4'b0000) begin errors++; $display("FAIL frozen_no_tick: got %b want 0000", tick_s); end
        tv_s = 1'b1;
        tw_s = 8'd64;
        step();
        tv_s = 1'b0;
        checks++; if (tr_s !== 1'b0) begin errors++; $display("FAIL frozen_ready_low: got %b want 0", tr_s); end
        step();
        checks++; if (tr_s !== 1'b1) begin errors++; $display("FAIL frozen_ready_back: got %b want 1", tr_s); end
        checks++; if (tick_s !== 4'b0000) begin errors++; $display("FAIL frozen_apply_tick: got %b want 0000", tick_s); end
        step();
        // acc 0 -> 64: only the channel sitting at 192 carries
        checks++; if (tick_s !== 4'b1000) begin errors++; $display("FAIL frozen_first_step: got %b want 1000", tick_s); end
    endtask

    task automatic test_sync_pattern();
        logic [3:0] et [0:4];
        logic [3:0] eg [0:3];
        int ti;
        et[0] = 4'b0000; et[1] = 4'b1000; et[2] = 4'b0100; et[3] = 4'b0010; et[4] = 4'b0001;
        eg[0] = 4'b1100; eg[1] = 4'b0110; eg[2] = 4'b0011; eg[3] = 4'b1001;
        sync_s_start(8'd64);
        checks++; if (tr_s !== 1'b1) begin errors++; $display("FAIL sync_ready: got %b want 1", tr_s); end
        for (int i = 0; i < 9; i++) begin
            if (i > 0) step();
            ti = (i == 0) ? 0 : ((i - 1) % 4) + 1;
            checks++; if (tick_s !== et[ti])    begin errors++; $display("FAIL pattern_tick[%0d]: got %b want %b", i, tick_s, et[ti]); end
            checks++; if (gc_s !== eg[i % 4])   begin errors++; $display("FAIL pattern_gclk[%0d]: got %b want %b", i, gc_s, eg[i % 4]); end
        end
    endtask

    task automatic test_retune();
        logic exp0;
        sync_s_start(8'd64);
        step();                     // acc = 64
        tv_s = 1'b1;
        tw_s = 8'd32;
        step();                     // accepted, acc = 128
        tv_s = 1'b0;
        checks++; if (tr_s !== 1'b0) begin errors++; $display("FAIL retune_ready_e2: got %b want 0", tr_s); end
        step();                     // acc = 192
        checks++; if (tr_s !== 1'b0) begin errors++; $display("FAIL retune_ready_e3: got %b want 0", tr_s); end
        step();                     // acc wraps to 0, new word takes over
        checks++; if (tr_s !== 1'b1)    begin errors++; $display("FAIL retune_ready_e4: got %b want 1", tr_s); end
        checks++; if (tick_s[0] !== 1'b1) begin errors++; $display("FAIL retune_wrap_tick: got %b want 1", tick_s[0]); end
        for (int e = 5; e <= 20; e++) begin
            step();
            exp0 = (e == 12) || (e == 20);
            checks++; if (tick_s[0] !== exp0) begin errors++; $display("FAIL retune_tick0[e%0d]: got %b want %b", e, tick_s[0], exp0); end
        end
    endtask

    task automatic test_enable_hold();
        sync_s_start(8'd64);
        step();                     // acc = 64, gen_clock 0110
        en_s = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            checks++; if (tick_s !== 4'b0000) begin errors++; $display("FAIL hold_tick[%0d]: got %b want 0000", i, tick_s); end
            checks++; if (gc_s !== 4'b0110)   begin errors++; $display("FAIL hold_gclk[%0d]: got %b want 0110", i, gc_s); end
        end
        en_s = 1'b1;
        step();
        checks++; if (tick_s !== 4'b0100) begin errors++; $display("FAIL resume_tick1: got %b want 0100", tick_s); end
        checks++; if (gc_s !== 4'b0011)   begin errors++; $display("FAIL resume_gclk1: got %b want 0011", gc_s); end
        step();
        checks++; if (tick_s !== 4'b0010) begin errors++; $display("FAIL resume_tick2: got %b want 0010", tick_s); end
        step();
        checks++; if (tick_s !== 4'b0001) begin errors++; $display("FAIL resume_tick3: got %b want 0001", tick_s); end
    endtask

    task automatic test_sync_mid();
        logic [3:0] exp;
        int cnt [0:3];
        for (int k = 0; k < 4; k++) cnt[k] = 0;
        sync_s_start(8'd64);
        step();
        step();                     // acc = 128; an unsynced step would tick channel 1
        sync_s = 1'b1;
        po_s   = {8'hFF, 8'h80, 8'h10, 8'h00};
        step();
        sync_s = 1'b0;
        po_s   = 32'h5A3C_7E11;     // ignored until the next sync
        checks++; if (tick_s !== 4'b0000) begin errors++; $display("FAIL midsync_tick: got %b want 0000", tick_s); end
        checks++; if (gc_s !== 4'b1100)   begin errors++; $display("FAIL midsync_gclk: got %b want 1100", gc_s); end
        for (int e = 1; e <= 16; e++) begin
            step();
            exp = {(e % 4 == 1), (e % 4 == 2), (e % 4 == 0), (e % 4 == 0)};
            checks++; if (tick_s !== exp) begin errors++; $display("FAIL midsync_seq[e%0d]: got %b want %b", e, tick_s, exp); end
            for (int k = 0; k < 4; k++) if (tick_s[k]) cnt[k]++;
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (cnt[k] != 4) begin errors++; $display("FAIL midsync_count[%0d]: got %0d want 4", k, cnt[k]); end
        end
    endtask

    // Default params: tune 3958242, 2^32/tune = 1085.069 clk per tick.
    task automatic test_default_rate();
        int cyc, t0_first, t0_last, n0, d;
        bit seen;
        cyc = 0; n0 = 0; seen = 1'b0; t0_first = 0; t0_last = 0;
        while (n0 < 21 && cyc < 30000) begin
            step();
            cyc++;
            if (tick_b[0]) begin
                if (seen) begin
                    d = cyc - t0_last;
                    checks++; if (d < 1085 || d > 1086) begin errors++; $display("FAIL rate_interval: got %0d want 1085..1086", d); end
                end else begin
                    t0_first = cyc;
                end
                seen = 1'b1;
                t0_last = cyc;
                n0++;
            end
            if (tick_b[2] && seen) begin
                d = cyc - t0_last;
                checks++; if (d < 542 || d > 543) begin errors++; $display("FAIL rate_trail2: got %0d want 542..543", d); end
            end
        end
        checks++; if (n0 != 21) begin errors++; $display("FAIL rate_timeout: got %0d ticks want 21", n0); end
        d = t0_last - t0_first;
        checks++; if (d < 21700 || d > 21703) begin errors++; $display("FAIL rate_span20: got %0d want 21700..21703", d); end
    endtask

    task automatic test_async_reset();
        int first [0:3];
        int want  [0:3];
        want[0] = 1086; want[1] = 814; want[2] = 543; want[3] = 272;
        for (int k = 0; k < 4; k++) first[k] = 0;
        tv_b = 1'b1;
        tw_b = 32'd1000000;
        step();
        checks++; if (tr_b !== 1'b0) begin errors++; $display("FAIL areset_pending: got %b want 0", tr_b); end
        checks++; if (gc_b === 4'b0000) begin errors++; $display("FAIL areset_running_gclk: got %b want nonzero", gc_b); end
        sync_b = 1'b1;
        #2;
        rst_b_n = 1'b0;
        #1;
        checks++; if (tick_b !== 4'b0000) begin errors++; $display("FAIL areset_tick: got %b want 0000", tick_b); end
        checks++; if (gc_b !== 4'b0000)   begin errors++; $display("FAIL areset_gclk: got %b want 0000", gc_b); end
        checks++; if (tr_b !== 1'b1)      begin errors++; $display("FAIL areset_ready: got %b want 1", tr_b); end
        step();
        tv_b   = 1'b0;
        sync_b = 1'b0;
        step();
        rst_b_n = 1'b1;
        for (int n = 1; n <= 1200; n++) begin
            step();
            for (int k = 0; k < 4; k++) if (tick_b[k] && first[k] == 0) first[k] = n;
        end
        for (int k = 0; k < 4; k++) begin
            checks++; if (first[k] != want[k]) begin errors++; $display("FAIL areset_first_tick[%0d]: got %0d want %0d", k, first[k], want[k]); end
        end
    endtask

    initial begin
        rst_b_n = 1'b0; en_b = 1'b1; tv_b = 1'b0; tw_b = '0; sync_b = 1'b0;
        po_b = {32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        rst_s_n = 1'b0; en_s = 1'b1; tv_s = 1'b0; tw_s = '0; sync_s = 1'b0;
        po_s = '0;
        test_reset();
        test_frozen_apply();
        test_sync_pattern();
        test_retune();
        test_enable_hold();
        test_sync_mid();
        test_default_rate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
